// File: rtl/l1_cache_pkg.sv
// rtl/l1_cache_pkg.sv - shared widths, address-field positions and FSM state encoding for the L1 cache
//   Holds default geometry (16-bit word address, 1024 lines of 4 words, 4-bit tag),
//   the bit positions of the {tag, index, offset} address fields and the controller state enum.
package l1_cache_pkg;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_INDEX_W  = 10;
    localparam int DEF_OFFSET_W = 2;
    localparam int DEF_TAG_W    = DEF_ADDR_W - DEF_INDEX_W - DEF_OFFSET_W;

    // Address field positions for the default geometry: addr = {tag, index, offset}
    localparam int OFFSET_LSB = 0;
    localparam int INDEX_LSB  = OFFSET_LSB + DEF_OFFSET_W;
    localparam int TAG_LSB    = INDEX_LSB + DEF_INDEX_W;

    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COMPARE   = 3'd1,
        ST_FILL      = 3'd2,
        ST_WRITE_MEM = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

endpackage

// File: rtl/l1_data_ram.sv
// rtl/l1_data_ram.sv - single-port cache data array, synchronous read and write
//   Ports: clk; en (access enable); we (1=write, 0=read); addr {index, offset};
//          wdata write word; rdata registered read word (holds when not reading).
module l1_data_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/l1_cache_ctrl.sv
// rtl/l1_cache_ctrl.sv - direct-mapped, write-through, no-write-allocate L1 cache controller
//   Ports: clk, reset (async, active-high);
//          CPU side : cpu_req, cpu_we, cpu_addr, cpu_wdata -> cpu_rdata, cpu_ready (1-cycle pulse);
//          memory   : mem_req, mem_we, mem_addr, mem_wdata -> mem_rdata, mem_ack (one word per ack);
//          stats    : hit_count, miss_count.
//   Optional build macro L1_CACHE_STATS_EN enables saturating hit/miss counters; otherwise they read 0.
module l1_cache_ctrl
    import l1_cache_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int OFFSET_W = DEF_OFFSET_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES  = 1 << INDEX_W;
    localparam int RAM_AW = INDEX_W + OFFSET_W;

    state_t             state;
    logic               lat_we;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem [LINES];

    logic [TAG_W-1:0]    lat_tag;
    logic [INDEX_W-1:0]  lat_index;
    logic [OFFSET_W-1:0] lat_offset;
    logic [OFFSET_W-1:0] fill_offset;
    logic                fill_last;
    logic                hit;

    assign lat_tag     = lat_addr[ADDR_W-1 -: TAG_W];
    assign lat_index   = lat_addr[OFFSET_W +: INDEX_W];
    assign lat_offset  = lat_addr[OFFSET_W-1:0];
    // During a fill the word being fetched is tracked by mem_addr itself
    assign fill_offset = mem_addr[OFFSET_W-1:0];
    assign fill_last   = &fill_offset;
    assign hit         = valid[lat_index] && (tag_mem[lat_index] == lat_tag);

    logic              ram_en;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // The RAM read for a lookup is launched from IDLE on the accept edge so the
    // word is ready in COMPARE; a write hit updates the word in COMPARE.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = lat_addr[RAM_AW-1:0];
        ram_wdata = lat_wdata;
        case (state)
            ST_IDLE: begin
                ram_en   = cpu_req;
                ram_addr = cpu_addr[RAM_AW-1:0];
            end
            ST_COMPARE: begin
                ram_en = lat_we && hit;
                ram_we = lat_we && hit;
            end
            ST_FILL: begin
                ram_en    = mem_ack;
                ram_we    = mem_ack;
                ram_addr  = {lat_index, fill_offset};
                ram_wdata = mem_rdata;
            end
            default: ;
        endcase
    end

    l1_data_ram #(
        .ADDR_W(RAM_AW),
        .DATA_W(DATA_W)
    ) u_data_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            valid     <= '0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        lat_we    <= cpu_we;
                        lat_addr  <= cpu_addr;
                        lat_wdata <= cpu_wdata;
                        state     <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (lat_we) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= lat_addr;
                        mem_wdata <= lat_wdata;
                        state     <= ST_WRITE_MEM;
                    end else if (hit) begin
                        cpu_rdata <= ram_rdata;
                        cpu_ready <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        // Line is invalid until the whole fill lands, so an
                        // aborted fill can never leave a half-written line valid.
                        valid[lat_index] <= 1'b0;
                        mem_req          <= 1'b1;
                        mem_we           <= 1'b0;
                        mem_addr         <= {lat_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        state            <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (mem_ack) begin
                        if (fill_offset == lat_offset) begin
                            cpu_rdata <= mem_rdata;
                        end
                        if (fill_last) begin
                            mem_req          <= 1'b0;
                            valid[lat_index] <= 1'b1;
                            cpu_ready        <= 1'b1;
                            state            <= ST_RESP;
                        end else begin
                            // Only the offset field advances: never crosses into the next line
                            mem_addr <= {mem_addr[ADDR_W-1:OFFSET_W], fill_offset + OFFSET_W'(1)};
                        end
                    end
                end
                ST_WRITE_MEM: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        cpu_ready <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Tags need no reset: a line is only trusted through its valid bit
    always_ff @(posedge clk) begin
        if (state == ST_FILL && mem_ack && fill_last) begin
            tag_mem[lat_index] <= lat_tag;
        end
    end

`ifdef L1_CACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == ST_COMPARE) begin
            if (hit) begin
                if (hit_cnt != STAT_MAX) hit_cnt <= hit_cnt + 16'd1;
            end else begin
                if (miss_cnt != STAT_MAX) miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end

    assign hit_count  = hit_cnt;
    assign miss_count = miss_cnt;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// tb/tb_l1_cache_ctrl.sv - self-checking bench for l1_cache_ctrl
module tb_l1_cache_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    always #5 clk = ~clk;

`ifdef L1_CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    l1_cache_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          delay;
        bit          hit;
    } vec_t;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_op_t;

    typedef struct {
        bit          is_read;
        logic [15:0] data;
    } rsp_t;

    int          tests = 0;
    int          fails = 0;
    mem_op_t     mem_q[$];
    rsp_t        rsp_q[$];
    logic [15:0] mem_model [0:65535];
    int          ack_delay = 0;
    int          ack_cnt = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: acks after ack_delay idle cycles, checks each accepted
    // operation against the expected-op queue and that request fields hold while waiting.
    initial begin
        int          cnt = 0;
        logic        prev_hold = 1'b0;
        logic [32:0] prev = '0;
        mem_op_t     op;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (prev_hold && mem_req) begin
                check("mem_hold", {mem_we, mem_addr, mem_wdata}, prev);
            end
            if (mem_req && !reset) begin
                if (cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    cnt = 0;
                    ack_cnt++;
                    mem_rdata = mem_we ? 16'h0000 : mem_model[mem_addr];
                    if (mem_we) mem_model[mem_addr] = mem_wdata;
                    if (mem_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL mem_unexpected: got we=%0b addr=%h, expected no memory access", mem_we, mem_addr);
                    end else begin
                        op = mem_q.pop_front();
                        check("mem_op", {mem_we, mem_addr, mem_we ? mem_wdata : 16'h0},
                                        {op.we, op.addr, op.we ? op.wdata : 16'h0});
                    end
                end else begin
                    mem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ack = 1'b0;
                cnt = 0;
            end
            prev_hold = mem_req && !mem_ack;
            prev      = {mem_we, mem_addr, mem_wdata};
        end
    end

    // CPU response scoreboard
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (cpu_ready) begin
                if (rsp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp_unexpected: got cpu_ready with rdata %h, expected none", cpu_rdata);
                end else begin
                    e = rsp_q.pop_front();
                    if (e.is_read) check("rsp_rdata", cpu_rdata, e.data);
                end
            end
        end
    end

    task automatic do_access(input vec_t v, input string name);
        int      n = 0;
        mem_op_t op;
        rsp_t    r;
        ack_delay = v.delay;
        if (v.we) begin
            op.we = 1'b1; op.addr = v.addr; op.wdata = v.wdata;
            mem_q.push_back(op);
        end else if (!v.hit) begin
            for (int i = 0; i < 4; i++) begin
                op.we = 1'b0; op.addr = {v.addr[15:2], 2'(i)}; op.wdata = 16'h0;
                mem_q.push_back(op);
            end
        end
        r.is_read = !v.we;
        r.data    = v.rdata;
        rsp_q.push_back(r);
        if (v.hit) exp_hits++; else exp_misses++;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        @(posedge clk);
        #1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = ~v.addr; cpu_wdata = ~v.wdata;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ready && n < 300);
        check({name, "_ready"}, cpu_ready, 1'b1);
        if (!v.we && v.hit) check({name, "_lat"}, n, 2);
        if (!v.we && !v.hit && v.delay == 0) check({name, "_lat"}, n, 6);
        if (v.we && v.delay == 0) check({name, "_lat"}, n, 3);
        @(negedge clk);
        check({name, "_pulse"}, cpu_ready, 1'b0);
        check({name, "_memq"}, mem_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        vec_t    vecs[13];
        mem_op_t op;
        rsp_t    r;
        int      n;
        int      base;

        for (int i = 0; i < 65536; i++) mem_model[i] = 16'(i) ^ 16'h5A5A;
        mem_model[16'h0010] = 16'hBEEF;

        //          we    addr      wdata     rdata     dly hit
        vecs[0]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 0, 1'b0};
        vecs[1]  = '{1'b0, 16'h0012, 16'h0000, 16'h5A48, 0, 1'b1};
        vecs[2]  = '{1'b1, 16'h0011, 16'h1234, 16'h0000, 0, 1'b1};
        vecs[3]  = '{1'b0, 16'h0011, 16'h0000, 16'h1234, 0, 1'b1};
        vecs[4]  = '{1'b1, 16'h4011, 16'h5555, 16'h0000, 0, 1'b0};
        vecs[5]  = '{1'b0, 16'h4011, 16'h0000, 16'h5555, 0, 1'b0};
        vecs[6]  = '{1'b0, 16'h0011, 16'h0000, 16'h1234, 0, 1'b0};
        vecs[7]  = '{1'b0, 16'hFFFF, 16'h0000, 16'hA5A5, 0, 1'b0};
        vecs[8]  = '{1'b0, 16'hFFFC, 16'h0000, 16'hA5A6, 0, 1'b1};
        vecs[9]  = '{1'b0, 16'h0000, 16'h0000, 16'h5A5A, 5, 1'b0};
        vecs[10] = '{1'b0, 16'h0003, 16'h0000, 16'h5A59, 0, 1'b1};
        vecs[11] = '{1'b1, 16'h0002, 16'hABCD, 16'h0000, 3, 1'b1};
        vecs[12] = '{1'b0, 16'h0002, 16'h0000, 16'hABCD, 0, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_cpu_ready", cpu_ready, 1'b0);
        check("rst_cpu_rdata", cpu_rdata, 16'h0000);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_wdata", mem_wdata, 16'h0000);
        check("rst_hit_count", hit_count, 16'h0000);
        check("rst_miss_count", miss_count, 16'h0000);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            do_access(vecs[i], $sformatf("vec%0d", i));
        end

        // cpu_req held high: request ignored while busy, next access starts from IDLE
        r.is_read = 1'b1; r.data = 16'h5A48; rsp_q.push_back(r);
        r.is_read = 1'b1; r.data = 16'h5A49; rsp_q.push_back(r);
        exp_hits += 2;
        ack_delay = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0012;
        @(negedge clk);
        cpu_addr = 16'h0013;
        n = 0;
        do begin @(negedge clk); n++; end while (!cpu_ready && n < 50);
        check("b2b_first_lat", n, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!cpu_ready && n < 50);
        check("b2b_second_gap", n, 3);
        cpu_req = 1'b0;
        @(negedge clk);
        check("b2b_pulse", cpu_ready, 1'b0);
        check("b2b_rspq", rsp_q.size(), 0);

        check("stat_hits", hit_count, STATS ? 16'(exp_hits) : 16'h0000);
        check("stat_misses", miss_count, STATS ? 16'(exp_misses) : 16'h0000);

        // Reset after the second fill ack aborts the fill
        ack_delay = 2;
        for (int i = 0; i < 2; i++) begin
            op.we = 1'b0; op.addr = 16'h0100 + 16'(i); op.wdata = 16'h0;
            mem_q.push_back(op);
        end
        base = ack_cnt;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        n = 0;
        while (ack_cnt < base + 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("abort_acks_seen", ack_cnt - base, 2);
        #1;
        reset = 1'b1;
        #1;
        check("abort_mem_req", mem_req, 1'b0);
        check("abort_mem_addr", mem_addr, 16'h0000);
        check("abort_cpu_ready", cpu_ready, 1'b0);
        check("abort_miss_count", miss_count, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_memq", mem_q.size(), 0);
        exp_hits = 0;
        exp_misses = 0;
        do_access('{1'b0, 16'h0100, 16'h0000, 16'h5B5A, 0, 1'b0}, "refill");
        check("refill_misses", miss_count, STATS ? 16'd1 : 16'h0000);
        check("refill_hits", hit_count, 16'h0000);
        check("final_rspq", rsp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
